narrow_serializer: RTL and testbench

NARROW_SERIALIZER -- requirements
Module: narrow_serializer

---
 rtl/narrow_serializer_pkg.sv | 23 ++
 rtl/narrow_serializer_if.sv | 26 ++
 rtl/narrow_serializer.sv | 98 +++++++++
 tb/tb_narrow_serializer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/narrow_serializer_pkg.sv
// Shared definitions for the 8-bit to 3-bit narrowing serializer.
package narrow_serializer_pkg;

  localparam int WORD_W    = 8;  // input word width
  localparam int FIELD_W   = 3;  // output field width
  localparam int NUM_BEATS = 3;  // beats needed to cover a full word

  // Beat index: counts 0..NUM_BEATS-1
  typedef logic [1:0] beat_t;

  localparam beat_t LAST_BEAT = beat_t'(NUM_BEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // A word is short when every bit above the first field is zero
  function automatic logic is_short(input logic [WORD_W-1:0] word);
    return (word[WORD_W-1:FIELD_W] == '0);
  endfunction

endpackage

// File: rtl/narrow_serializer_if.sv
// Producer-side and consumer-side handshake bundle of the serializer.
interface narrow_serializer_if;
  import narrow_serializer_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [WORD_W-1:0]  in_data;
  logic               out_valid;
  logic               out_ready;
  logic [FIELD_W-1:0] out_field;
  logic               out_last;
  logic               out_short;

  // Environment side: drives words in, accepts beats out
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_field, out_last, out_short
  );

  // Serializer side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_field, out_last, out_short
  );

endinterface

// File: rtl/narrow_serializer.sv
// Splits each accepted 8-bit word into 3-bit beats, LSB beat first.
// Words that fit in 3 bits go out as a single beat.
module narrow_serializer
  import narrow_serializer_pkg::*;
#(
  parameter int WORD_W  = narrow_serializer_pkg::WORD_W,
  parameter int FIELD_W = narrow_serializer_pkg::FIELD_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  narrow_serializer_if.slave   bus
);

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  beat_t              beat_q, beat_d;
  logic               short_q, short_d;

  logic               in_ready;
  logic               out_valid;
  logic [FIELD_W-1:0] out_field;
  logic               out_last;
  logic               out_short;

  // State register with synchronous reset; a reset mid-word drops the word
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      beat_q  <= '0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      beat_q  <= beat_d;
      short_q <= short_d;
    end
  end

  // Next-state logic and registered-state-decoded outputs
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d   = state_q;
    word_d    = word_q;
    beat_d    = beat_q;
    short_d   = short_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_field = '0;
    out_last  = 1'b0;
    out_short = 1'b0;

    unique case (state_q)
      IDLE: begin
        // in_ready depends on state only, never on out_ready
        in_ready = 1'b1;
        if (bus.in_valid) begin
          word_d  = bus.in_data;
          short_d = is_short(bus.in_data);
          beat_d  = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        out_valid = 1'b1;
        out_short = short_q;
        out_last  = short_q || (beat_q == LAST_BEAT);
        // 3-way field select on the beat index
        case (beat_q)
          2'd0:    out_field = word_q[2:0];
          2'd1:    out_field = word_q[5:3];
          default: out_field = {1'b0, word_q[7:6]};
        endcase
        if (bus.out_ready) begin
          if (out_last) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 2'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_field = out_field;
  assign bus.out_last  = out_last;
  assign bus.out_short = out_short;

endmodule

// File: tb/tb_narrow_serializer.sv
// Directed bench for narrow_serializer: fixed vectors with hand-computed
// beats, reset abort, back-to-back words, and a full 256-word sweep.
module tb_narrow_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  narrow_serializer_if bus ();

  narrow_serializer #(.WORD_W(8), .FIELD_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled and inputs driven at the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_beat(input string tag, input logic [2:0] field,
                            input logic last, input logic short_w);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_field"}, 32'(bus.out_field), 32'(field));
    check({tag, "_last"},  32'(bus.out_last),  32'(last));
    check({tag, "_short"}, 32'(bus.out_short), 32'(short_w));
  endtask

  // Push one word with random out_ready, rebuild it from the beats
  task automatic send_word(input logic [7:0] d);
    logic [7:0] rebuilt;
    logic [2:0] first_field;
    logic [2:0] prev_field;
    logic       prev_last;
    logic       seen_short;
    logic       stalled;
    logic       done;
    int         nbeats;
    int         budget;

    bus.in_valid = 1'b1;
    bus.in_data  = d;
    budget = 0;
    while (!bus.in_ready && budget < 20) begin
      tick();
      budget++;
    end
    check("sweep_accept", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("sweep_latency", 32'(bus.out_valid), 32'd1);

    rebuilt     = '0;
    first_field = '0;
    prev_field  = '0;
    prev_last   = 1'b0;
    seen_short  = 1'b0;
    stalled     = 1'b0;
    done        = 1'b0;
    nbeats      = 0;
    budget      = 0;
    while (!done && budget < 100) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid) begin
        if (stalled) begin
          check("sweep_hold_field", 32'(bus.out_field), 32'(prev_field));
          check("sweep_hold_last",  32'(bus.out_last),  32'(prev_last));
        end
        if (bus.out_ready) begin
          if (nbeats == 0) begin
            first_field = bus.out_field;
            seen_short  = bus.out_short;
          end
          if (nbeats < 3)
            rebuilt = rebuilt | (8'(bus.out_field) << (3 * nbeats));
          nbeats++;
          done = bus.out_last;
        end
        stalled    = !bus.out_ready;
        prev_field = bus.out_field;
        prev_last  = bus.out_last;
      end
      tick();
      budget++;
    end
    check("sweep_done", 32'(done), 32'd1);
    check("sweep_word", 32'(rebuilt), 32'(d));
    check("sweep_nbeats", 32'(nbeats), (d < 8'd8) ? 32'd1 : 32'd3);
    check("sweep_short", 32'(seen_short), (d < 8'd8) ? 32'd1 : 32'd0);
    if (d < 8'd8)
      check("sweep_zext", 32'({5'b0, first_field}), 32'(d));
    check("sweep_idle", 32'(bus.out_valid), 32'd0);
  endtask

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_field", 32'(bus.out_field), 32'd0);
    check("rst_last",  32'(bus.out_last),  32'd0);
    check("rst_short", 32'(bus.out_short), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", 32'(bus.in_ready), 32'd1);

    // 0x05: one short beat, one cycle after acceptance
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h05;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check_beat("w05", 3'b101, 1'b1, 1'b1);
    check("w05_busy", 32'(bus.in_ready), 32'd0);
    tick();
    check("w05_idle_valid", 32'(bus.out_valid), 32'd0);
    check("w05_idle_ready", 32'(bus.in_ready), 32'd1);

    // 0xB6 with out_ready high: 110, 110, 010
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hB6;
    tick();
    bus.in_valid = 1'b0;
    check_beat("wb6_b0", 3'b110, 1'b0, 1'b0);
    tick();
    check_beat("wb6_b1", 3'b110, 1'b0, 1'b0);
    tick();
    check_beat("wb6_b2", 3'b010, 1'b1, 1'b0);
    tick();
    check("wb6_idle", 32'(bus.out_valid), 32'd0);

    // 0xFF with a 4-cycle stall on beat 1
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    tick();
    bus.in_valid = 1'b0;
    check_beat("wff_b0", 3'b111, 1'b0, 1'b0);
    tick();
    check_beat("wff_b1", 3'b111, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_beat("wff_hold", 3'b111, 1'b0, 1'b0);
    end
    bus.out_ready = 1'b1;
    tick();
    check_beat("wff_b2", 3'b011, 1'b1, 1'b0);
    tick();
    check("wff_idle", 32'(bus.out_valid), 32'd0);

    // Reset right after beat 0 of 0xB6 aborts the word
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hB6;
    tick();
    bus.in_valid = 1'b0;
    check_beat("abort_b0", 3'b110, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_quiet", 32'(bus.out_valid), 32'd0);
    end

    // in_valid held with 0x07 while 0xB6 is in flight
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hB6;
    tick();
    bus.in_data = 8'h07;
    check_beat("bb_b0", 3'b110, 1'b0, 1'b0);
    tick();
    check_beat("bb_b1", 3'b110, 1'b0, 1'b0);
    tick();
    check_beat("bb_b2", 3'b010, 1'b1, 1'b0);
    tick();
    check("bb_gap_valid", 32'(bus.out_valid), 32'd0);
    check("bb_gap_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check_beat("bb_w07", 3'b111, 1'b1, 1'b1);
    tick();
    check("bb_idle", 32'(bus.out_valid), 32'd0);

    // Every input value with random backpressure
    for (int v = 0; v < 256; v++)
      send_word(8'(v));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
